// File: rtl/zx_bus_dma_ctrl_if.sv
// Z80 shared-bus signal bundle for zx_bus_dma_ctrl.
//
// master modport: the DMA controller (drives request, address, strobes, write data).
// slave modport : the Z80 side / memory model (drives BUSACK and read data).
//
// Signals:
//   bus_req_n    Z80 BUSREQ, active low
//   bus_ack_n    Z80 BUSACK, active low, asynchronous to clk
//   bus_drive    tri-state enable for bus_addr and bus_ctrl
//   bus_addr     Z80 address
//   bus_ctrl     {mreq_n, iorq_n, rd_n, wr_n}
//   bus_data_out data driven during writes
//   bus_data_oe  data bus output enable
//   bus_data_in  sampled Z80 data bus
interface zx_bus_dma_ctrl_if;
    logic        bus_req_n;
    logic        bus_ack_n;
    logic        bus_drive;
    logic [15:0] bus_addr;
    logic [3:0]  bus_ctrl;
    logic [7:0]  bus_data_out;
    logic        bus_data_oe;
    logic [7:0]  bus_data_in;

    modport master (
        output bus_req_n, bus_drive, bus_addr, bus_ctrl, bus_data_out, bus_data_oe,
        input  bus_ack_n, bus_data_in
    );

    modport slave (
        input  bus_req_n, bus_drive, bus_addr, bus_ctrl, bus_data_out, bus_data_oe,
        output bus_ack_n, bus_data_in
    );
endinterface

// File: rtl/zx_bus_dma_ctrl.sv
// Z80 bus-takeover DMA sequencer between the SD loader and Spectrum memory.
//
// Requests the bus with BUSREQ, waits for a synchronised BUSACK, then runs timed memory
// read or write cycles over a contiguous address range and hands the bus back.
//
// Optional build macro: ZX_DMA_ACK_TIMEOUT_EN adds a BUSACK timeout that aborts the
// command with a sticky error; without it REQ waits forever and error is tied low.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cmd_start/write/addr/len   command: pulse start, direction, first address, byte count
//   busy, done, error     status: busy span, one-cycle completion, sticky abort flag
//   wr_data/valid/ready   loader-to-Z80 byte stream (consumed on valid & ready)
//   rd_data/valid         Z80-to-loader bytes, one-cycle strobe per byte
//   bus                   Z80 bus bundle (zx_bus_dma_ctrl_if.master)
module zx_bus_dma_ctrl #(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 4,
    parameter int unsigned ACK_TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_len,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    zx_bus_dma_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StAddr,
        StSetup,
        StStrobe,
        StRecover,
        StRelease
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] len_q, len_d;
    logic        write_q, write_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  data_out_q, data_out_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic [1:0]  ack_sync_q;
    logic        ack_s;

`ifdef ZX_DMA_ACK_TIMEOUT_EN
    logic        error_q, error_d;
    logic [15:0] to_cnt_q, to_cnt_d;
`endif

    // Synchroniser resets to "not acknowledged" (bus_ack_n high).
    assign ack_s = ~ack_sync_q[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= 16'h0000;
            len_q      <= 16'h0000;
            write_q    <= 1'b0;
            cnt_q      <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= 8'h00;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            ack_sync_q <= 2'b11;
`ifdef ZX_DMA_ACK_TIMEOUT_EN
            error_q    <= 1'b0;
            to_cnt_q   <= 16'h0000;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            write_q    <= write_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ack_sync_q <= {ack_sync_q[0], bus.bus_ack_n};
`ifdef ZX_DMA_ACK_TIMEOUT_EN
            error_q    <= error_d;
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        write_d    = write_q;
        cnt_d      = cnt_q;
        // busy stays up through the done cycle and drops right after it
        busy_d     = busy_q & ~done_q;
        done_d     = 1'b0;
        data_out_d = data_out_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
`ifdef ZX_DMA_ACK_TIMEOUT_EN
        error_d    = error_q;
        to_cnt_d   = to_cnt_q;
`endif

        case (state_q)
            StIdle: begin
                if (cmd_start && !busy_q) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    write_d = cmd_write;
                    busy_d  = 1'b1;
`ifdef ZX_DMA_ACK_TIMEOUT_EN
                    error_d  = 1'b0;
                    to_cnt_d = 16'h0000;
`endif
                    if (cmd_len == 16'h0000) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StReq;
                    end
                end
            end

            StReq: begin
                if (ack_s) begin
                    state_d = StAddr;
                end
`ifdef ZX_DMA_ACK_TIMEOUT_EN
                else if (to_cnt_q == 16'(ACK_TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + 16'h0001;
                end
`endif
            end

            StAddr: begin
                if (!write_q) begin
                    cnt_d   = 4'd0;
                    state_d = StSetup;
                end else if (wr_valid) begin
                    data_out_d = wr_data;
                    cnt_d      = 4'd0;
                    state_d    = StSetup;
                end
            end

            StSetup: begin
                if (cnt_q == 4'(SETUP_CYCLES - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = StStrobe;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            StStrobe: begin
                if (cnt_q == 4'(STROBE_CYCLES - 1)) begin
                    state_d = StRecover;
                    if (!write_q) begin
                        // sample on the final strobe clock so rd_valid lands in RECOVER
                        rd_data_d  = bus.bus_data_in;
                        rd_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            StRecover: begin
                addr_d  = addr_q + 16'h0001;
                len_d   = len_q - 16'h0001;
                state_d = (len_q == 16'h0001) ? StRelease : StAddr;
            end

            StRelease: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ready         = (state_q == StAddr) && write_q;
        bus.bus_req_n    = !((state_q == StReq) || (state_q == StAddr) ||
                             (state_q == StSetup) || (state_q == StStrobe) ||
                             (state_q == StRecover));
        bus.bus_drive    = (state_q == StAddr) || (state_q == StSetup) ||
                           (state_q == StStrobe) || (state_q == StRecover);
        // data enable only spans write cycles, strictly inside the bus_drive window
        bus.bus_data_oe  = write_q && ((state_q == StSetup) || (state_q == StStrobe) ||
                                       (state_q == StRecover));
        bus.bus_ctrl     = 4'b1111;
        if (state_q == StStrobe) begin
            bus.bus_ctrl = {1'b0, 1'b1, write_q, ~write_q};
        end
        bus.bus_addr     = addr_q;
        bus.bus_data_out = data_out_q;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

`ifdef ZX_DMA_ACK_TIMEOUT_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_zx_bus_dma_ctrl.sv
// Self-checking bench for zx_bus_dma_ctrl: Z80 BUSACK/memory model, write-stream feeder,
// and scoreboard queues of expected bus writes, read addresses and read bytes.
module tb_zx_bus_dma_ctrl;
    localparam int unsigned SETUP  = 1;
    localparam int unsigned STROBE = 4;
    localparam int unsigned TMO    = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_start = 1'b0;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = 16'h0000;
    logic [15:0] cmd_len = 16'h0000;
    logic        busy, done, error;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;

    zx_bus_dma_ctrl_if bus_if ();

    zx_bus_dma_ctrl #(
        .SETUP_CYCLES (SETUP),
        .STROBE_CYCLES(STROBE),
        .ACK_TIMEOUT  (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_start(cmd_start),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .bus      (bus_if.master)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard queues
    logic [23:0] wr_exp_q[$];
    logic [15:0] rd_addr_exp_q[$];
    logic [7:0]  rd_data_exp_q[$];

    // Z80 side: BUSACK follows BUSREQ after ack_delay clocks, changing mid-cycle.
    logic [7:0] mem [0:65535];
    int  ack_delay = 5;
    bit  ack_en = 1'b1;
    int  ack_cnt = 0;

    initial bus_if.bus_ack_n = 1'b1;

    always @(negedge clk) begin
        if (bus_if.bus_req_n) begin
            ack_cnt = 0;
            bus_if.bus_ack_n <= 1'b1;
        end else if (ack_en) begin
            ack_cnt++;
            if (ack_cnt >= ack_delay) bus_if.bus_ack_n <= 1'b0;
        end
    end

    assign bus_if.bus_data_in = (bus_if.bus_drive && !bus_if.bus_ctrl[1]) ?
                                mem[bus_if.bus_addr] : 8'h00;

    // Bus monitor
    int cyc = 0;
    int wr_len = 0, rd_len = 0;
    logic [15:0] wr_addr, rd_addr;
    logic [7:0]  wr_dat;
    int strobe_cnt = 0, done_cnt = 0, req_low_cnt = 0;
    int oe_bad = 0, ctrl_bad = 0;
    int ack_cyc = 0, drive_cyc = 0;
    logic prev_ack = 1'b1, prev_drive = 1'b0;

    always @(negedge clk) begin
        logic [31:0] e;
        cyc++;
        if (reset) begin
            wr_len = 0;
            rd_len = 0;
        end else begin
            if (!bus_if.bus_ctrl[0]) begin
                wr_len++;
                wr_addr = bus_if.bus_addr;
                wr_dat  = bus_if.bus_data_out;
                if (!bus_if.bus_data_oe) oe_bad++;
            end else if (wr_len != 0) begin
                strobe_cnt++;
                check("wr_pulse_len", 32'(wr_len), 32'(STROBE));
                e = (wr_exp_q.size() != 0) ? 32'(wr_exp_q.pop_front()) : 32'hFFFF_FFFF;
                check("wr_addr_data", {8'h00, wr_addr, wr_dat}, e);
                wr_len = 0;
            end
            if (!bus_if.bus_ctrl[1]) begin
                rd_len++;
                rd_addr = bus_if.bus_addr;
            end else if (rd_len != 0) begin
                strobe_cnt++;
                check("rd_pulse_len", 32'(rd_len), 32'(STROBE));
                e = (rd_addr_exp_q.size() != 0) ? 32'(rd_addr_exp_q.pop_front())
                                                : 32'hFFFF_FFFF;
                check("rd_addr", 32'(rd_addr), e);
                rd_len = 0;
            end
            if (rd_valid) begin
                e = (rd_data_exp_q.size() != 0) ? 32'(rd_data_exp_q.pop_front())
                                                : 32'hFFFF_FFFF;
                check("rd_data", 32'(rd_data), e);
            end
            if ((!bus_if.bus_ctrl[0] || !bus_if.bus_ctrl[1]) &&
                (bus_if.bus_ctrl[3] || !bus_if.bus_drive)) ctrl_bad++;
            if (!bus_if.bus_ctrl[2]) ctrl_bad++;
            if (bus_if.bus_data_oe && (!bus_if.bus_drive || !bus_if.bus_ctrl[1])) oe_bad++;
            if (done) done_cnt++;
            if (!bus_if.bus_req_n) req_low_cnt++;
            if (prev_ack && !bus_if.bus_ack_n) ack_cyc = cyc;
            if (!prev_drive && bus_if.bus_drive) drive_cyc = cyc;
        end
        prev_ack   = bus_if.bus_ack_n;
        prev_drive = bus_if.bus_drive;
    end

    // Stimulus helpers
    logic [7:0] wr_bytes[$];
    int stall_seen = 0, stall_bad = 0;

    task automatic start_cmd(input logic wr, input logic [15:0] a, input logic [15:0] n);
        @(negedge clk);
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = n;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    // Feeds wr_bytes in order; withholds wr_valid for 'stall' clocks before the first byte.
    task automatic feed_bytes(input int stall, input logic [15:0] a0);
        repeat (stall) begin
            @(negedge clk);
            if (wr_ready) begin
                stall_seen++;
                if (!bus_if.bus_drive || bus_if.bus_addr !== a0 || bus_if.bus_ctrl !== 4'hF)
                    stall_bad++;
            end
        end
        for (int i = 0; i < wr_bytes.size(); i++) begin
            wr_data  = wr_bytes[i];
            wr_valid = 1'b1;
            for (int t = 0; t < 300; t++) begin
                if (wr_ready) break;
                @(negedge clk);
            end
            check("wr_ready_seen", 32'(wr_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
            wr_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0, r0;

        mem[16'hFFFF] = 8'h12;
        mem[16'h0000] = 8'h34;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_flags", {24'h0, busy, done, error, wr_ready, rd_valid, bus_if.bus_req_n,
                            bus_if.bus_drive, bus_if.bus_data_oe}, 32'b0000_0100);
        check("rst_addr", 32'(bus_if.bus_addr), 32'h0);
        check("rst_ctrl", 32'(bus_if.bus_ctrl), 32'hF);
        check("rst_data", {16'h0, bus_if.bus_data_out, rd_data}, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: write 3 bytes at 0x4000, ack after 5 clocks
        ack_delay = 5;
        s0 = strobe_cnt;
        d0 = done_cnt;
        wr_bytes = '{8'hAA, 8'h55, 8'hC3};
        wr_exp_q.push_back({16'h4000, 8'hAA});
        wr_exp_q.push_back({16'h4001, 8'h55});
        wr_exp_q.push_back({16'h4002, 8'hC3});
        start_cmd(1'b1, 16'h4000, 16'd3);
        check("t1_req_low", 32'(bus_if.bus_req_n), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        fork
            feed_bytes(0, 16'h4000);
            wait_done(400);
        join
        repeat (4) @(negedge clk);
        // ack changes mid-cycle: two synchroniser clocks until bus_drive rises
        check("t1_ack_to_drive", 32'(drive_cyc - ack_cyc), 32'd2);
        check("t1_strobes", 32'(strobe_cnt - s0), 32'd3);
        check("t1_done_once", 32'(done_cnt - d0), 32'd1);
        check("t1_released", {30'h0, bus_if.bus_req_n, bus_if.bus_drive}, 32'b10);
        check("t1_busy_low", 32'(busy), 32'd0);
        check("t1_error", 32'(error), 32'd0);

        // 2: read 2 bytes at 0xFFFF, address wraps to 0x0000
        ack_delay = 3;
        s0 = strobe_cnt;
        rd_addr_exp_q.push_back(16'hFFFF);
        rd_addr_exp_q.push_back(16'h0000);
        rd_data_exp_q.push_back(8'h12);
        rd_data_exp_q.push_back(8'h34);
        start_cmd(1'b0, 16'hFFFF, 16'd2);
        wait_done(400);
        repeat (4) @(negedge clk);
        check("t2_strobes", 32'(strobe_cnt - s0), 32'd2);
        check("t2_rd_left", 32'(rd_addr_exp_q.size() + rd_data_exp_q.size()), 32'd0);

        // 3: zero-length command
        r0 = req_low_cnt;
        start_cmd(1'b1, 16'h1234, 16'd0);
        check("t3_done", 32'(done), 32'd1);
        @(negedge clk);
        check("t3_done_pulse", 32'(done), 32'd0);
        repeat (5) @(negedge clk);
        check("t3_no_req", 32'(req_low_cnt - r0), 32'd0);
        check("t3_busy_low", 32'(busy), 32'd0);

        // 4: write stream withheld for 20 clocks
        ack_delay = 2;
        s0 = strobe_cnt;
        wr_bytes = '{8'h3C, 8'h96};
        wr_exp_q.push_back({16'h2000, 8'h3C});
        wr_exp_q.push_back({16'h2001, 8'h96});
        start_cmd(1'b1, 16'h2000, 16'd2);
        fork
            feed_bytes(20, 16'h2000);
            wait_done(400);
        join
        repeat (4) @(negedge clk);
        check("t4_stall_seen", 32'(stall_seen >= 10), 32'd1);
        check("t4_stall_bad", 32'(stall_bad), 32'd0);
        check("t4_strobes", 32'(strobe_cnt - s0), 32'd2);
        check("t4_wr_left", 32'(wr_exp_q.size()), 32'd0);

        // 5: reset during STROBE
        wr_bytes = '{8'h5A};
        start_cmd(1'b1, 16'h6000, 16'd1);
        fork
            feed_bytes(0, 16'h6000);
            begin
                for (int t = 0; t < 300; t++) begin
                    @(negedge clk);
                    if (!bus_if.bus_ctrl[0]) break;
                end
            end
        join
        check("t5_in_strobe", 32'(bus_if.bus_ctrl[0]), 32'd0);
        @(negedge clk);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        check("t5_flags", {24'h0, busy, done, error, wr_ready, rd_valid, bus_if.bus_req_n,
                           bus_if.bus_drive, bus_if.bus_data_oe}, 32'b0000_0100);
        check("t5_addr", 32'(bus_if.bus_addr), 32'h0);
        check("t5_ctrl", 32'(bus_if.bus_ctrl), 32'hF);
        check("t5_data", {16'h0, bus_if.bus_data_out, rd_data}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);

`ifdef ZX_DMA_ACK_TIMEOUT_EN
        // 6: BUSACK never arrives
        ack_en = 1'b0;
        s0 = strobe_cnt;
        start_cmd(1'b1, 16'h8000, 16'd4);
        wait_done(TMO + 8);
        check("t6_error", 32'(error), 32'd1);
        check("t6_req_high", 32'(bus_if.bus_req_n), 32'd1);
        @(negedge clk);
        check("t6_busy_low", 32'(busy), 32'd0);
        check("t6_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        ack_en = 1'b1;
`endif

        check("oe_invariant", 32'(oe_bad), 32'd0);
        check("ctrl_invariant", 32'(ctrl_bad), 32'd0);
        check("queues_empty", 32'(wr_exp_q.size() + rd_addr_exp_q.size() +
                                  rd_data_exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
